// File: rtl/pool_window_gen.sv
// Streaming 3x3 window generator feeding the max-pool stage.
// Two line buffers plus a 3x3 shift register; stride gating uses phase counters.
module pool_window_gen #(
    parameter int DATA_W = 16,
    parameter int IMG_W  = 8,
    parameter int IMG_H  = 8,
    parameter int STRIDE = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] din,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] win1,
    output logic [DATA_W-1:0] win2,
    output logic [DATA_W-1:0] win3,
    output logic [DATA_W-1:0] win4,
    output logic [DATA_W-1:0] win5,
    output logic [DATA_W-1:0] win6,
    output logic [DATA_W-1:0] win7,
    output logic [DATA_W-1:0] win8,
    output logic [DATA_W-1:0] win9,
    output logic              frame_done
);
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam int SW = (STRIDE > 1) ? $clog2(STRIDE) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
    localparam logic [SW-1:0] PH_LAST  = SW'(STRIDE - 1);

    logic [CW-1:0]     r_col;
    logic [RW-1:0]     r_row;
    logic [SW-1:0]     r_cph;
    logic [SW-1:0]     r_rph;
    logic [DATA_W-1:0] r_sr  [9];
    logic [DATA_W-1:0] r_win [9];
    logic [DATA_W-1:0] r_lb1 [IMG_W];
    logic [DATA_W-1:0] r_lb2 [IMG_W];
    logic              r_ov;
    logic              r_fd;

    logic              w_acc;
    logic              w_col_last;
    logic              w_row_last;
    logic              w_col_ok;
    logic              w_row_ok;
    logic              w_complete;
    logic [DATA_W-1:0] w_sr_nxt [9];

    assign in_ready   = !(r_ov && !out_ready);
    assign w_acc      = in_valid && in_ready;
    assign w_col_last = (r_col == COL_LAST);
    assign w_row_last = (r_row == ROW_LAST);
    assign w_col_ok   = (r_col >= CW'(2));
    assign w_row_ok   = (r_row >= RW'(2));
    // Phase counters hold (c-2) mod STRIDE and (r-2) mod STRIDE once past the border.
    assign w_complete = w_acc && w_col_ok && w_row_ok && (r_cph == '0) && (r_rph == '0);

    always_comb begin
        for (int unsigned i = 0; i < 3; i++) begin
            w_sr_nxt[3*i]     = r_sr[3*i + 1];
            w_sr_nxt[3*i + 1] = r_sr[3*i + 2];
        end
        w_sr_nxt[2] = r_lb2[r_col];
        w_sr_nxt[5] = r_lb1[r_col];
        w_sr_nxt[8] = din;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_col <= '0;
            r_row <= '0;
            r_cph <= '0;
            r_rph <= '0;
            r_ov  <= 1'b0;
            r_fd  <= 1'b0;
            for (int unsigned i = 0; i < 9; i++) begin
                r_sr[i]  <= '0;
                r_win[i] <= '0;
            end
        end else begin
            r_fd <= w_acc && w_col_last && w_row_last;
            if (w_acc) begin
                r_sr <= w_sr_nxt;
                if (w_col_last) begin
                    r_col <= '0;
                    r_cph <= '0;
                    if (w_row_last) begin
                        r_row <= '0;
                        r_rph <= '0;
                    end else begin
                        r_row <= r_row + RW'(1);
                        if (w_row_ok)
                            r_rph <= (r_rph == PH_LAST) ? '0 : r_rph + SW'(1);
                    end
                end else begin
                    r_col <= r_col + CW'(1);
                    if (w_col_ok)
                        r_cph <= (r_cph == PH_LAST) ? '0 : r_cph + SW'(1);
                end
            end
            if (w_complete) begin
                r_win <= w_sr_nxt;
                r_ov  <= 1'b1;
            end else if (out_ready) begin
                r_ov  <= 1'b0;
            end
        end
    end

    // Line-buffer RAM is intentionally not reset.
    always_ff @(posedge clk) begin
        if (w_acc) begin
            r_lb2[r_col] <= r_lb1[r_col];
            r_lb1[r_col] <= din;
        end
    end

    assign out_valid  = r_ov;
    assign frame_done = r_fd;
    assign win1 = r_win[0];
    assign win2 = r_win[1];
    assign win3 = r_win[2];
    assign win4 = r_win[3];
    assign win5 = r_win[4];
    assign win6 = r_win[5];
    assign win7 = r_win[6];
    assign win8 = r_win[7];
    assign win9 = r_win[8];
endmodule

// File: tb/tb_pool_window_gen.sv
// Bench for pool_window_gen: STRIDE 1 and STRIDE 3 instances against a window-list model.
module tb_pool_window_gen;
    localparam int DW = 16;
    localparam int W  = 8;
    localparam int H  = 8;
    localparam int WB = 9 * DW;
    localparam logic [WB-1:0] FIRST1 = {16'd0, 16'd1, 16'd2, 16'd8, 16'd9, 16'd10, 16'd16, 16'd17, 16'd18};
    localparam logic [WB-1:0] FIRST6 = {16'd100, 16'd101, 16'd102, 16'd108, 16'd109, 16'd110,
                                        16'd116, 16'd117, 16'd118};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n, iv, ordy, sel3;
    logic [DW-1:0] d;
    logic          iv1, iv3, ordy1, ordy3, ir1, ir3, ov1, ov3, fd1, fd3;
    logic [DW-1:0] w1 [9];
    logic [DW-1:0] w3 [9];
    logic          ir, ov, fd;
    logic [WB-1:0] wp;

    assign iv1   = iv & ~sel3;
    assign iv3   = iv & sel3;
    assign ordy1 = sel3 ? 1'b1 : ordy;
    assign ordy3 = sel3 ? ordy : 1'b1;
    assign ir    = sel3 ? ir3 : ir1;
    assign ov    = sel3 ? ov3 : ov1;
    assign fd    = sel3 ? fd3 : fd1;
    assign wp    = sel3 ? {w3[0], w3[1], w3[2], w3[3], w3[4], w3[5], w3[6], w3[7], w3[8]}
                        : {w1[0], w1[1], w1[2], w1[3], w1[4], w1[5], w1[6], w1[7], w1[8]};

    pool_window_gen #(.DATA_W(DW), .IMG_W(W), .IMG_H(H), .STRIDE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1), .din(d),
        .out_valid(ov1), .out_ready(ordy1),
        .win1(w1[0]), .win2(w1[1]), .win3(w1[2]), .win4(w1[3]), .win5(w1[4]),
        .win6(w1[5]), .win7(w1[6]), .win8(w1[7]), .win9(w1[8]), .frame_done(fd1));

    pool_window_gen #(.DATA_W(DW), .IMG_W(W), .IMG_H(H), .STRIDE(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv3), .in_ready(ir3), .din(d),
        .out_valid(ov3), .out_ready(ordy3),
        .win1(w3[0]), .win2(w3[1]), .win3(w3[2]), .win4(w3[3]), .win5(w3[4]),
        .win6(w3[5]), .win7(w3[6]), .win8(w3[7]), .win9(w3[8]), .frame_done(fd3));

    // Transfer monitor: records every handed-off window and counts frame_done pulses.
    int            cap_n = 0;
    int            fd_n  = 0;
    logic [WB-1:0] cap [0:511];
    always @(negedge clk) begin
        if (ov && ordy && cap_n < 512) begin
            cap[cap_n] <= wp;
            cap_n      <= cap_n + 1;
        end
        if (fd) fd_n <= fd_n + 1;
    end

    int            n_chk  = 0;
    int            n_pass = 0;
    logic [WB-1:0] exp_q [$];

    task automatic chk(input string tag, input logic [WB-1:0] obs, input logic [WB-1:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    function automatic int pixval(input int idx, input int base_a, input int base_b);
        return ((idx / (W*H)) == 0 ? base_a : base_b) + (idx % (W*H));
    endfunction

    function automatic bit completes(input int p, input int s);
        int r = p / W;
        int c = p % W;
        return (r >= 2) && (c >= 2) && ((r-2) % s == 0) && ((c-2) % s == 0);
    endfunction

    function automatic logic [WB-1:0] win_at(input int base, input int r, input int c);
        logic [WB-1:0] w = '0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                w[WB-1-(3*i+j)*DW -: DW] = DW'(base + W*(r-2+i) + (c-2+j));
        return w;
    endfunction

    task automatic build_exp(input int base, input int s);
        for (int r = 2; r < H; r++)
            for (int c = 2; c < W; c++)
                if ((r-2) % s == 0 && (c-2) % s == 0)
                    exp_q.push_back(win_at(base, r, c));
    endtask

    task automatic compare_caps(input int start, input string tag);
        int n = cap_n - start;
        chk({tag, "_count"}, WB'(n), WB'(exp_q.size()));
        for (int i = 0; i < n && i < exp_q.size(); i++)
            chk({tag, "_win"}, cap[start+i], exp_q[i]);
        exp_q.delete();
    endtask

    task automatic run(input int base_a, input int base_b, input int npix,
                       input bit rnd, input bit bp, input bit tchk);
        int idx = 0;
        int cyc = 0;
        int stall = 0;
        bit bp_done = 0;
        bit acc;
        int s = sel3 ? 3 : 1;
        while (idx < npix && cyc < 20000) begin
            d    = DW'(pixval(idx, base_a, base_b));
            iv   = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            ordy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (bp && !bp_done && ov) begin
                stall   = 5;
                bp_done = 1;
            end
            if (stall > 0) ordy = 1'b0;
            @(negedge clk);
            acc = iv && ir;
            if (stall > 0) begin
                chk("bp_in_ready", WB'(ir), WB'(0));
                chk("bp_hold", wp, FIRST1);
                stall--;
            end
            @(posedge clk);
            #1;
            if (acc) begin
                if (tchk) chk("valid_timing", WB'(ov), WB'(completes(idx % (W*H), s)));
                idx++;
            end
            cyc++;
        end
        chk("pixel_budget", WB'(idx), WB'(npix));
        iv   = 1'b0;
        ordy = 1'b1;
        repeat (4) @(posedge clk);
        #1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int start, f0;
        sel3 = 1'b0; iv = 1'b0; ordy = 1'b1; d = '0; rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", WB'(ov), WB'(0));
        chk("rst_frame_done", WB'(fd), WB'(0));
        chk("rst_win", wp, '0);
        chk("rst_in_ready", WB'(ir), WB'(1));
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Stride 1, continuous stream
        start = cap_n; f0 = fd_n;
        run(0, 0, 64, 0, 0, 1);
        chk("s1_first", cap[start], FIRST1);
        chk("s1_last_win9", WB'(cap[start+35][DW-1:0]), WB'(63));
        chk("s1_frame_done", WB'(fd_n - f0), WB'(1));
        build_exp(0, 1);
        compare_caps(start, "s1");

        // Stride 3
        sel3 = 1'b1;
        start = cap_n; f0 = fd_n;
        run(0, 0, 64, 0, 0, 1);
        chk("s2_frame_done", WB'(fd_n - f0), WB'(1));
        build_exp(0, 3);
        compare_caps(start, "s2");
        sel3 = 1'b0;

        // Backpressure on the first window
        start = cap_n; f0 = fd_n;
        run(0, 0, 64, 0, 1, 0);
        chk("s3_frame_done", WB'(fd_n - f0), WB'(1));
        build_exp(0, 1);
        compare_caps(start, "s3");

        // Random input gaps and random out_ready
        start = cap_n; f0 = fd_n;
        run(0, 0, 64, 1, 0, 0);
        chk("s4_frame_done", WB'(fd_n - f0), WB'(1));
        build_exp(0, 1);
        compare_caps(start, "s4");

        // Reset mid-frame
        run(0, 0, 20, 0, 0, 0);
        rst_n = 1'b0;
        #1;
        chk("s5_rst_valid", WB'(ov), WB'(0));
        chk("s5_rst_win", wp, '0);
        @(posedge clk);
        #1;
        chk("s5_rst_fd", WB'(fd), WB'(0));
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        start = cap_n; f0 = fd_n;
        run(0, 0, 64, 0, 0, 1);
        chk("s5_frame_done", WB'(fd_n - f0), WB'(1));
        build_exp(0, 1);
        compare_caps(start, "s5");

        // Two back-to-back frames, no bubble
        start = cap_n; f0 = fd_n;
        run(0, 100, 128, 0, 0, 1);
        chk("s6_frame_done", WB'(fd_n - f0), WB'(2));
        chk("s6_first2", cap[start+36], FIRST6);
        build_exp(0, 1);
        build_exp(100, 1);
        compare_caps(start, "s6");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
